// File: rtl/lsu_mem_pkg.sv
// Shared types and sizing helpers for the LSU data-memory responder.
package lsu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESPOND
  } resp_state_t;

  localparam int DEF_THREADS   = 4;
  localparam int DEF_ADDR_BITS = 8;
  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_LATENCY   = 2;

  function automatic int mem_depth(input int abits);
    return 2 ** abits;
  endfunction

  // Counter only has to hold MEM_LATENCY-1.
  function automatic int cnt_bits(input int lat);
    return (lat > 2) ? $clog2(lat) : 1;
  endfunction

  localparam int MEM_DEPTH = mem_depth(DEF_ADDR_BITS);
  localparam int CNT_BITS  = cnt_bits(DEF_LATENCY);

endpackage

// File: rtl/lsu_mem_responder_rr_arbiter.sv
// Combinational round-robin pick: lowest requester at or after ptr,
// wrapping around.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);

  logic          found;
  logic [IW-1:0] pos;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = IW'((int'(ptr) + k) % N);
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        index      = pos;
      end
    end
  end

endmodule

// File: rtl/lsu_mem_responder.sv
// Serves LSU read/write channels from a local array, one request at a
// time, round-robin, with a fixed access latency.
module lsu_mem_responder
  import lsu_mem_pkg::*;
#(
  parameter int THREADS_PER_BLOCK  = DEF_THREADS,
  parameter int DATA_MEM_ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_MEM_DATA_BITS = DEF_DATA_BITS,
  parameter int MEM_LATENCY        = DEF_LATENCY
) (
  input  logic clk,
  input  logic reset,
  input  logic [THREADS_PER_BLOCK-1:0]
    data_mem_read_valid,
  input  logic [THREADS_PER_BLOCK-1:0][DATA_MEM_ADDR_BITS-1:0]
    data_mem_read_address,
  output logic [THREADS_PER_BLOCK-1:0]
    data_mem_read_ready,
  output logic [THREADS_PER_BLOCK-1:0][DATA_MEM_DATA_BITS-1:0]
    data_mem_read_data,
  input  logic [THREADS_PER_BLOCK-1:0]
    data_mem_write_valid,
  input  logic [THREADS_PER_BLOCK-1:0][DATA_MEM_ADDR_BITS-1:0]
    data_mem_write_address,
  input  logic [THREADS_PER_BLOCK-1:0][DATA_MEM_DATA_BITS-1:0]
    data_mem_write_data,
  output logic [THREADS_PER_BLOCK-1:0]
    data_mem_write_ready,
  input  logic                          init_write_enable,
  input  logic [DATA_MEM_ADDR_BITS-1:0] init_write_address,
  input  logic [DATA_MEM_DATA_BITS-1:0] init_write_data,
  output logic                          busy
);

  localparam int T     = THREADS_PER_BLOCK;
  localparam int A     = DATA_MEM_ADDR_BITS;
  localparam int D     = DATA_MEM_DATA_BITS;
  localparam int IW    = (T > 1) ? $clog2(T) : 1;
  localparam int CW    = cnt_bits(MEM_LATENCY);
  localparam int DEPTH = mem_depth(A);

  resp_state_t   state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] sel;
  logic [IW-1:0] rr_ptr;
  logic          op_write;
  logic [A-1:0]  addr;
  logic [D-1:0]  wdata;

  logic [T-1:0]  req;
  logic [T-1:0]  grant;
  logic [IW-1:0] gidx;
  logic          commit;
  logic          sel_valid;

  logic [D-1:0]  mem [DEPTH];

  assign req       = data_mem_read_valid | data_mem_write_valid;
  assign commit    = (state == ACCESS) && (cnt == '0);
  assign busy      = (state != IDLE);
  assign sel_valid = op_write ? data_mem_write_valid[sel]
                              : data_mem_read_valid[sel];

  rr_arbiter #(
    .N  (T),
    .IW (IW)
  ) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (grant),
    .index (gidx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      cnt                 <= '0;
      sel                 <= '0;
      rr_ptr              <= '0;
      op_write            <= 1'b0;
      addr                <= '0;
      wdata               <= '0;
      data_mem_read_ready  <= '0;
      data_mem_write_ready <= '0;
      data_mem_read_data   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|grant) begin
            sel   <= gidx;
            cnt   <= CW'(MEM_LATENCY - 1);
            wdata <= data_mem_write_data[gidx];
            state <= ACCESS;
            rr_ptr <= (gidx == IW'(T - 1)) ? '0 : gidx + 1'b1;
            // A pending read outranks a write on the same channel.
            if (data_mem_read_valid[gidx]) begin
              op_write <= 1'b0;
              addr     <= data_mem_read_address[gidx];
            end else begin
              op_write <= 1'b1;
              addr     <= data_mem_write_address[gidx];
            end
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state <= RESPOND;
            if (op_write) begin
              data_mem_write_ready[sel] <= 1'b1;
            end else begin
              data_mem_read_ready[sel] <= 1'b1;
              data_mem_read_data[sel]  <= mem[addr];
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESPOND: begin
          if (!sel_valid) begin
            data_mem_read_ready  <= '0;
            data_mem_write_ready <= '0;
            state                <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Backdoor preload is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (!reset && commit && op_write) begin
      mem[addr] <= wdata;
    end
    if (init_write_enable) begin
      mem[init_write_address] <= init_write_data;
    end
  end

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Scoreboard bench for lsu_mem_responder: expected responses are queued
// at request time and checked when a ready bit rises.
module tb_lsu_mem_responder;

  localparam int T = 4;
  localparam int A = 8;
  localparam int D = 8;
  localparam int L = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [T-1:0]        data_mem_read_valid = '0;
  logic [T-1:0][A-1:0] data_mem_read_address = '0;
  logic [T-1:0]        data_mem_read_ready;
  logic [T-1:0][D-1:0] data_mem_read_data;
  logic [T-1:0]        data_mem_write_valid = '0;
  logic [T-1:0][A-1:0] data_mem_write_address = '0;
  logic [T-1:0][D-1:0] data_mem_write_data = '0;
  logic [T-1:0]        data_mem_write_ready;
  logic                init_write_enable = 1'b0;
  logic [A-1:0]        init_write_address = '0;
  logic [D-1:0]        init_write_data = '0;
  logic                busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int         lsu;
    bit         wr;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  lsu_mem_responder #(
    .THREADS_PER_BLOCK  (T),
    .DATA_MEM_ADDR_BITS (A),
    .DATA_MEM_DATA_BITS (D),
    .MEM_LATENCY        (L)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .data_mem_read_valid    (data_mem_read_valid),
    .data_mem_read_address  (data_mem_read_address),
    .data_mem_read_ready    (data_mem_read_ready),
    .data_mem_read_data     (data_mem_read_data),
    .data_mem_write_valid   (data_mem_write_valid),
    .data_mem_write_address (data_mem_write_address),
    .data_mem_write_data    (data_mem_write_data),
    .data_mem_write_ready   (data_mem_write_ready),
    .init_write_enable      (init_write_enable),
    .init_write_address     (init_write_address),
    .init_write_data        (init_write_data),
    .busy                   (busy)
  );

  // Response monitor: one-hot readies, bubble between responses,
  // each rising ready matched against the scoreboard head.
  logic [2*T-1:0] prev = '0;
  always @(negedge clk) begin
    logic [2*T-1:0] cur;
    logic [2*T-1:0] rises;
    logic [2*T-1:0] want;
    exp_t e;
    cur   = {data_mem_write_ready, data_mem_read_ready};
    rises = cur & ~prev;
    if (!reset) begin
      tests++;
      if ($countones(cur) > 1) begin
        fails++;
        $display("FAIL onehot: ready=%b required at most one bit", cur);
      end
    end
    if (rises != 0) begin
      tests++;
      if (prev != 0) begin
        fails++;
        $display("FAIL bubble: ready %b rose while %b high", rises, prev);
      end else if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected: ready=%b required none", rises);
      end else begin
        e = sb.pop_front();
        want = '0;
        want[e.wr ? T + e.lsu : e.lsu] = 1'b1;
        if (rises !== want) begin
          fails++;
          $display("FAIL order: ready=%b required %b", rises, want);
        end else if (!e.wr &&
                     data_mem_read_data[e.lsu] !== e.data) begin
          fails++;
          $display("FAIL rdata%0d: got %h required %h",
                   e.lsu, data_mem_read_data[e.lsu], e.data);
        end
      end
    end
    prev = cur;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    init_write_enable  = 1'b1;
    init_write_address = a;
    init_write_data    = d;
    @(posedge clk);
    #1;
    init_write_enable = 1'b0;
  endtask

  task automatic start_read(input int lsu, input logic [7:0] a,
                            input logic [7:0] d);
    exp_t e;
    e = '{lsu, 1'b0, d};
    sb.push_back(e);
    data_mem_read_address[lsu] = a;
    data_mem_read_valid[lsu]   = 1'b1;
  endtask

  task automatic start_write(input int lsu, input logic [7:0] a,
                             input logic [7:0] d);
    exp_t e;
    e = '{lsu, 1'b1, 8'h00};
    sb.push_back(e);
    data_mem_write_address[lsu] = a;
    data_mem_write_data[lsu]    = d;
    data_mem_write_valid[lsu]   = 1'b1;
  endtask

  // Plays the LSU side: drop each valid once its ready is seen.
  task automatic serve(input int budget);
    int n = 0;
    while ((data_mem_read_valid | data_mem_write_valid |
            data_mem_read_ready | data_mem_write_ready) != 0 || busy) begin
      @(negedge clk);
      data_mem_read_valid  = data_mem_read_valid & ~data_mem_read_ready;
      data_mem_write_valid = data_mem_write_valid & ~data_mem_write_ready;
      n++;
      if (n > budget) begin
        tests++;
        fails++;
        $display("FAIL timeout: %0d cycles required <= %0d", n, budget);
        data_mem_read_valid  = '0;
        data_mem_write_valid = '0;
        break;
      end
    end
  endtask

  task automatic check_drained(input string name);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d responses outstanding required 0",
               name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (data_mem_read_ready !== '0) begin
      fails++;
      $display("FAIL rst_rready: %b required 0", data_mem_read_ready);
    end
    tests++;
    if (data_mem_write_ready !== '0) begin
      fails++;
      $display("FAIL rst_wready: %b required 0", data_mem_write_ready);
    end
    tests++;
    if (data_mem_read_data !== '0) begin
      fails++;
      $display("FAIL rst_rdata: %h required 0", data_mem_read_data);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_busy: %b required 0", busy);
    end
    reset = 1'b0;
  endtask

  task automatic test_read_latency;
    logic exp_rdy [3];
    exp_rdy = '{1'b0, 1'b0, 1'b1};
    preload(8'h10, 8'hA5);
    @(posedge clk);
    #1;
    start_read(0, 8'h10, 8'hA5);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      tests++;
      if (data_mem_read_ready[0] !== exp_rdy[c]) begin
        fails++;
        $display("FAIL lat_c%0d: ready=%b required %b",
                 c, data_mem_read_ready[0], exp_rdy[c]);
      end
    end
    tests++;
    if (data_mem_read_data[0] !== 8'hA5) begin
      fails++;
      $display("FAIL lat_data: %h required a5", data_mem_read_data[0]);
    end
    data_mem_read_valid[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (data_mem_read_ready[0] !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL lat_drop: ready=%b busy=%b required 0 0",
               data_mem_read_ready[0], busy);
    end
    tests++;
    if (data_mem_read_data[0] !== 8'hA5) begin
      fails++;
      $display("FAIL lat_hold: %h required a5", data_mem_read_data[0]);
    end
    check_drained("latency");
  endtask

  task automatic test_write_then_read;
    @(posedge clk);
    #1;
    start_write(2, 8'h20, 8'h3C);
    serve(50);
    @(posedge clk);
    #1;
    start_read(1, 8'h20, 8'h3C);
    serve(50);
    check_drained("wr_rd");
  endtask

  task automatic test_back_to_back;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < T; i++) begin
      preload(8'(8'h50 + i), 8'(8'h60 + i));
    end
    for (int r = 0; r < 2; r++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < T; i++) begin
        start_read(i, 8'(8'h50 + i), 8'(8'h60 + i));
      end
      serve(200);
      check_drained("burst");
    end
  endtask

  task automatic test_read_and_write;
    preload(8'h30, 8'h5A);
    @(posedge clk);
    #1;
    start_read(3, 8'h30, 8'h5A);
    start_write(3, 8'h30, 8'hC3);
    serve(100);
    @(posedge clk);
    #1;
    start_read(0, 8'h30, 8'hC3);
    serve(50);
    check_drained("rd_wr");
  endtask

  task automatic test_reset_mid;
    preload(8'h05, 8'h11);
    @(posedge clk);
    #1;
    data_mem_write_address[1] = 8'h05;
    data_mem_write_data[1]    = 8'hEE;
    data_mem_write_valid[1]   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_busy: %b required 1", busy);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if ({data_mem_read_ready, data_mem_write_ready} !== '0 ||
        busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_rst: ready=%b busy=%b required 0 0",
               {data_mem_write_ready, data_mem_read_ready}, busy);
    end
    data_mem_write_valid = '0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    start_read(0, 8'h05, 8'h11);
    serve(50);
    check_drained("reset_mid");
  endtask

  task automatic test_init_collision;
    @(posedge clk);
    #1;
    start_write(2, 8'h40, 8'h99);
    repeat (2) @(posedge clk);
    #1;
    init_write_enable  = 1'b1;
    init_write_address = 8'h40;
    init_write_data    = 8'h77;
    @(posedge clk);
    #1;
    init_write_enable = 1'b0;
    serve(50);
    @(posedge clk);
    #1;
    start_read(0, 8'h40, 8'h77);
    serve(50);
    check_drained("collision");
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_write_then_read();
    test_back_to_back();
    test_read_and_write();
    test_reset_mid();
    test_init_collision();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu_mem_responder.md
Name: lsu_mem_responder

Overview:
Responder end of the LSU data-memory read/write channels. It accepts requests from THREADS_PER_BLOCK LSU initiators (one core's data_mem read and write channels) and serves them from an internal word-addressed memory array. Requests are handled one at a time under round-robin arbitration, with a programmable access latency. It completes the valid/ready four-phase handshake the LSUs use, and sits between a core's data_mem channels and backing storage in simulation and FPGA bring-up builds.

Parameters:
THREADS_PER_BLOCK, 4, number of initiator channels (one per LSU)
DATA_MEM_ADDR_BITS, 8, address width; array depth = 2**DATA_MEM_ADDR_BITS
DATA_MEM_DATA_BITS, 8, word width
MEM_LATENCY, 2, cycles spent in ACCESS; legal range is 1..15

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
data_mem_read_valid  in  [T]  per-LSU read request
data_mem_read_address  in  [T][A]  read address, held while valid is high
data_mem_read_ready  out  [T]  read response valid
data_mem_read_data  out  [T][D]  read data, held while ready is high
data_mem_write_valid  in  [T]  per-LSU write request
data_mem_write_address  in  [T][A]  write address
data_mem_write_data  in  [T][D]  write data
data_mem_write_ready  out  [T]  write acknowledge
init_write_enable  in  1  backdoor preload strobe
init_write_address  in  A  preload address
init_write_data  in  D  preload data
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state goes to IDLE; all read_ready and write_ready are 0; all read_data are 0; round-robin pointer is 0; latency counter is 0; busy is 0. Memory contents are NOT cleared.
- Request from LSU i means read_valid[i] OR write_valid[i]. If both are high, the read is served first; the write stays pending.
- Arbitration happens in IDLE only. On a clock edge with at least one request, grant the lowest index at or after rr_ptr, with wrap-around. Latch the index, op, address and write data, then go to ACCESS with counter = MEM_LATENCY-1.
- After each grant, rr_ptr = granted index + 1 (mod T).
- ACCESS: decrement the counter each edge. On the edge where counter == 0:
  - Read: capture mem[addr] into read_data[i].
  - Write: commit mem[addr] = data.
  - In both cases go to RESPOND and drive the matching ready[i] high.
- Latency: if the request is sampled at edge E0, ready[i] rises after edge E0+MEM_LATENCY.
- RESPOND: hold ready[i] and read_data[i] stable while the granted valid is high. On the first edge that samples the granted valid low, clear ready[i] and return to IDLE.
- Back-to-back: at least one IDLE cycle separates responses. The next grant can occur on the edge after the return to IDLE.
- read_data[i] keeps its last value after ready falls.
- Only the granted LSU ever sees ready high. At most one ready bit is high across all 2T outputs.
- Granted valid dropping during ACCESS (protocol violation): the access still completes and ready is asserted. It is cleared on the next edge in RESPOND because valid is sampled low there.
- init_write_enable commits on any edge, in any state. If it coincides with a granted write commit to the same address, init data wins. A read commit on the same edge returns the pre-write (old) value.
- Reset asserted mid-operation: the in-flight read is abandoned. An in-flight write that has not reached its commit edge is dropped. All ready outputs are 0 on the following cycle.
- Addresses use the full width with no bounds check; all 2**A locations are valid.

Decomposition:
- Shared package lsu_mem_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} resp_state_t
  - localparam MEM_DEPTH = 2**DATA_MEM_ADDR_BITS
  - the counter width derived from MEM_LATENCY
- Sub-module rr_arbiter (parameter N): request vector + pointer in, one-hot grant and encoded index out, purely combinational. The pointer register stays in lsu_mem_responder.

Test Plan:
- Preload mem[0x10]=0xA5 via init; LSU0 read 0x10 with MEM_LATENCY=2 -> read_ready[0] rises exactly 2 cycles after the sampling edge, data=0xA5; drops one edge after valid falls.
- LSU2 writes 0x3C to 0x20, handshake completes, then LSU1 reads 0x20 -> returns 0x3C; write_ready never seen on LSU1.
- All 4 LSUs request reads of distinct preloaded addresses in the same cycle -> served in order 0,1,2,3, each with its own data, one IDLE bubble between; next simultaneous burst starts at index 0 again (pointer wrapped).
- LSU3 holds read and write valid together -> read served first, then write; mem updated only after write handshake.
- Reset asserted during ACCESS of a write to 0x05 (old 0x11) -> all ready 0 next cycle, mem[0x05] still 0x11, busy 0.
- init write 0x77 and granted write 0x99 to 0x40 on same commit edge -> mem[0x40]=0x77; granted LSU still receives write_ready.
